// File: rtl/priority_encoder_arbiter.sv
// Priority/round-robin request encoder with a one-entry registered result; 1-cycle latency.
// Result is held stable until accepted via Ready_In; a handshake and new load may share an edge.
module priority_encoder_arbiter #(
    parameter int N_INPUTS  = 16,
    parameter int IDX_WIDTH = $clog2(N_INPUTS)
) (
    input  logic                 Clock_In,
    input  logic                 Reset_In,
    input  logic                 Enable_In,
    input  logic [1:0]           Mode_In,
    input  logic [N_INPUTS-1:0]  Data_In,
    input  logic                 Ready_In,
    output logic                 Valid_Out,
    output logic [IDX_WIDTH-1:0] Encoded_Value_Out,
    output logic [N_INPUTS-1:0]  Grant_Out
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] hi_idx;
    logic [IDX_WIDTH-1:0] lo_idx;
    logic [IDX_WIDTH-1:0] rr_idx;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic [IDX_WIDTH-1:0] ptr_nxt;
    logic                 slot_free;
    logic                 do_load;
    int                   rr_pos;

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        rr_idx = '0;
        rr_pos = 0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (Data_In[i]) hi_idx = IDX_WIDTH'(i);
        end
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (Data_In[i]) lo_idx = IDX_WIDTH'(i);
        end
        // Walk the offsets downward so the smallest offset from the pointer wins.
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            rr_pos = (int'(rr_ptr) + k) % N_INPUTS;
            if (Data_In[rr_pos]) rr_idx = IDX_WIDTH'(rr_pos);
        end
    end

    always_comb begin
        case (Mode_In)
            2'd1:    sel_idx = lo_idx;
            2'd2:    sel_idx = rr_idx;
            default: sel_idx = hi_idx;
        endcase
    end

    assign ptr_nxt   = (sel_idx == IDX_WIDTH'(N_INPUTS - 1)) ? '0 : sel_idx + IDX_WIDTH'(1);
    assign slot_free = (state == EMPTY) || Ready_In;
    assign do_load   = slot_free && Enable_In && (|Data_In);
    assign Valid_Out = (state == FULL);

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state             <= EMPTY;
            Encoded_Value_Out <= '0;
            Grant_Out         <= '0;
            rr_ptr            <= '0;
        end else if (slot_free) begin
            if (do_load) begin
                state             <= FULL;
                Encoded_Value_Out <= sel_idx;
                Grant_Out         <= N_INPUTS'(1) << sel_idx;
                if (Mode_In == 2'd2) rr_ptr <= ptr_nxt;
            end else begin
                state             <= EMPTY;
                Encoded_Value_Out <= '0;
                Grant_Out         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Directed and random checks of the encoder/arbiter against a queue-based reference model.
module tb_priority_encoder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] data;
    logic [11:0] data12;
    logic        rdy;
    logic        vld;
    logic [3:0]  enc;
    logic [15:0] grant;
    logic        vld12;
    logic [3:0]  enc12;
    logic [11:0] grant12;

    int total = 0;
    int bad   = 0;

    int q_exp[$];
    bit m_valid;
    int m_cur;
    int m_ptr;

    always #5 clk = ~clk;

    priority_encoder_arbiter #(.N_INPUTS(16)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
        .Data_In(data), .Ready_In(rdy), .Valid_Out(vld),
        .Encoded_Value_Out(enc), .Grant_Out(grant)
    );

    priority_encoder_arbiter #(.N_INPUTS(12)) dut12 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
        .Data_In(data12), .Ready_In(rdy), .Valid_Out(vld12),
        .Encoded_Value_Out(enc12), .Grant_Out(grant12)
    );

    function automatic int m_sel(input logic [63:0] d, input logic [1:0] md, input int ptr, input int n);
        int r;
        r = -1;
        if (md == 2'd1) begin
            for (int i = 0; i < n && r < 0; i++) if (d[i]) r = i;
        end else if (md == 2'd2) begin
            for (int k = 0; k < n && r < 0; k++) if (d[(ptr + k) % n]) r = (ptr + k) % n;
        end else begin
            for (int i = n - 1; i >= 0 && r < 0; i--) if (d[i]) r = i;
        end
        return r;
    endfunction

    // One clock of stimulus for the 16-input instance, checked against the model.
    task automatic step(input string name);
        bit          load;
        int          e;
        logic [3:0]  exp_enc;
        logic [15:0] exp_grant;
        load = 1'b0;
        if (!m_valid || rdy) begin
            if (en && data != 16'h0) begin
                e = m_sel({48'h0, data}, mode, m_ptr, 16);
                q_exp.push_back(e);
                load    = 1'b1;
                m_valid = 1'b1;
                if (mode == 2'd2) m_ptr = (e == 15) ? 0 : e + 1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (load) m_cur = q_exp.pop_front();
        exp_enc   = m_valid ? 4'(m_cur) : 4'h0;
        exp_grant = m_valid ? (16'h1 << m_cur) : 16'h0;
        total++;
        if (vld !== m_valid) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", name, vld, m_valid);
        end
        total++;
        if (enc !== exp_enc) begin
            bad++;
            $display("FAIL %s enc: got %0d want %0d", name, enc, exp_enc);
        end
        total++;
        if (grant !== exp_grant) begin
            bad++;
            $display("FAIL %s grant: got %h want %h", name, grant, exp_grant);
        end
        total++;
        if (dut.rr_ptr !== 4'(m_ptr)) begin
            bad++;
            $display("FAIL %s ptr: got %0d want %0d", name, dut.rr_ptr, m_ptr);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        q_exp.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_cur   = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 2'd0; data = 16'h0; data12 = 12'h0; rdy = 1'b0;
        m_valid = 1'b0; m_ptr = 0; m_cur = 0;
        #12;
        total++;
        if (vld !== 1'b0 || enc !== 4'h0 || grant !== 16'h0) begin
            bad++;
            $display("FAIL reset outputs: got vld=%b enc=%0d grant=%h want 0/0/0", vld, enc, grant);
        end
        total++;
        if (vld12 !== 1'b0 || enc12 !== 4'h0 || grant12 !== 12'h0) begin
            bad++;
            $display("FAIL reset outputs12: got vld=%b enc=%0d grant=%h want 0/0/0", vld12, enc12, grant12);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode0();
        en = 1'b1; rdy = 1'b1; mode = 2'd0; data = 16'h8421;
        step("mode0_8421");
        total++;
        if (enc !== 4'd15 || grant !== 16'h8000) begin
            bad++;
            $display("FAIL mode0_const: got enc=%0d grant=%h want 15/8000", enc, grant);
        end
        mode = 2'd3; data = 16'h0106;
        step("mode3_as_0");
    endtask

    task automatic test_mode1();
        mode = 2'd1; data = 16'h8420;
        step("mode1_8420");
        total++;
        if (enc !== 4'd5 || grant !== 16'h0020) begin
            bad++;
            $display("FAIL mode1_const: got enc=%0d grant=%h want 5/0020", enc, grant);
        end
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{0, 3, 0, 3};
        int exp_p[4] = '{1, 4, 1, 4};
        apply_reset();
        en = 1'b1; rdy = 1'b1; mode = 2'd2; data = 16'h0009;
        for (int i = 0; i < 4; i++) begin
            step("rr_0009");
            total++;
            if (enc !== 4'(exp_g[i]) || dut.rr_ptr !== 4'(exp_p[i])) begin
                bad++;
                $display("FAIL rr_seq[%0d]: got enc=%0d ptr=%0d want %0d/%0d", i, enc, dut.rr_ptr, exp_g[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_hold();
        en = 1'b1; rdy = 1'b1; mode = 2'd0; data = 16'h0100;
        step("hold_load");
        rdy = 1'b0; data = 16'hFFFF; mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step("hold_stall");
            total++;
            if (enc !== 4'd8 || vld !== 1'b1) begin
                bad++;
                $display("FAIL hold_enc: got enc=%0d vld=%b want 8/1", enc, vld);
            end
        end
        rdy = 1'b1; data = 16'h0;
        step("hold_drain");
        total++;
        if (vld !== 1'b0) begin
            bad++;
            $display("FAIL hold_drain_vld: got %b want 0", vld);
        end
    endtask

    task automatic test_enable();
        en = 1'b0; rdy = 1'b1; mode = 2'd0; data = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            step("enable_off");
            total++;
            if (vld !== 1'b0 || enc !== 4'h0) begin
                bad++;
                $display("FAIL enable_off: got vld=%b enc=%0d want 0/0", vld, enc);
            end
        end
    endtask

    task automatic test_reset_mid_full();
        en = 1'b1; rdy = 1'b0; mode = 2'd2; data = 16'h0010;
        step("midrst_load");
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (vld !== 1'b0 || enc !== 4'h0 || grant !== 16'h0 || dut.rr_ptr !== 4'h0) begin
            bad++;
            $display("FAIL midrst_async: got vld=%b enc=%0d grant=%h ptr=%0d want 0/0/0/0",
                     vld, enc, grant, dut.rr_ptr);
        end
        q_exp.delete();
        m_valid = 1'b0; m_ptr = 0; m_cur = 0;
        @(negedge clk);
        rst = 1'b0;
        data = 16'h0040; mode = 2'd1;
        step("first_after_reset");
    endtask

    task automatic test_back_to_back();
        en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            data = 16'($urandom_range(1, 16'hFFFF));
            mode = 2'($urandom_range(0, 3));
            step("b2b");
            total++;
            if (vld !== 1'b1) begin
                bad++;
                $display("FAIL b2b_continuous[%0d]: got %b want 1", i, vld);
            end
        end
        for (int i = 0; i < 40; i++) begin
            data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 4) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            step("random");
        end
    endtask

    task automatic test_n12();
        int exp_g[3] = '{0, 11, 0};
        int exp_p[3] = '{1, 0, 1};
        apply_reset();
        en = 1'b1; rdy = 1'b1; mode = 2'd2; data = 16'h0; data12 = 12'h801;
        for (int i = 0; i < 3; i++) begin
            step("n12_idle16");
            total++;
            if (vld12 !== 1'b1 || enc12 !== 4'(exp_g[i]) || grant12 !== (12'h1 << exp_g[i])) begin
                bad++;
                $display("FAIL n12_grant[%0d]: got vld=%b enc=%0d grant=%h want 1/%0d", i, vld12, enc12, grant12, exp_g[i]);
            end
            total++;
            if (dut12.rr_ptr !== 4'(exp_p[i])) begin
                bad++;
                $display("FAIL n12_ptr[%0d]: got %0d want %0d", i, dut12.rr_ptr, exp_p[i]);
            end
        end
        data12 = 12'h0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_round_robin();
        test_hold();
        test_enable();
        test_reset_mid_full();
        test_back_to_back();
        test_n12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/priority_encoder_arbiter.md
PRIORITY_ENCODER_ARBITER -- requirements
Module: priority_encoder_arbiter

Parameters
REQ-001 The block SHALL have parameter N_INPUTS, default 16, giving the number of request inputs; the legal range is 2..64 and the value need not be a power of two.
REQ-002 The block SHALL have derived parameter IDX_WIDTH, default $clog2(N_INPUTS), giving the width of the encoded index.

Interface
REQ-003 The block SHALL have Clock_In, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have Reset_In, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have Enable_In, input, 1 bit: permits sampling of Data_In.
REQ-006 The block SHALL have Mode_In, input, 2 bits, with these encodings:
- 0: high priority.
- 1: low priority.
- 2: round-robin.
- 3: reserved, treated as 0.
REQ-007 The block SHALL have Data_In, input, N_INPUTS bits: the request vector; bit i is request i.
REQ-008 The block SHALL have Ready_In, input, 1 bit: the consumer accepts the current result.
REQ-009 The block SHALL have Valid_Out, output, 1 bit: the result register holds an unaccepted result.
REQ-010 The block SHALL have Encoded_Value_Out, output, IDX_WIDTH bits: the index of the granted request.
REQ-011 The block SHALL have Grant_Out, output, N_INPUTS bits: the one-hot form of Encoded_Value_Out.

Function
REQ-012 The block SHALL implement a two-state output machine:
- EMPTY (Valid_Out=0).
- FULL (Valid_Out=1).
REQ-013 A slot is free when state is EMPTY, or when state is FULL and Ready_In=1 in the same cycle (handshake).
REQ-014 On a rising edge with slot free, Enable_In=1 and Data_In nonzero, the block SHALL load the result register, set Valid_Out=1 and go to FULL.
- Latency is exactly 1 cycle from sampled Data_In to Valid_Out.
REQ-015 On a rising edge with slot free and (Enable_In=0 or Data_In=0), the block SHALL go to EMPTY.
- Encoded_Value_Out and Grant_Out are cleared to 0.
REQ-016 In FULL with Ready_In=0, the block SHALL hold Encoded_Value_Out, Grant_Out and Valid_Out stable and ignore Data_In, Mode_In and Enable_In.
REQ-017 The selection rule per mode SHALL be:
- Mode 0: index of the highest set bit of Data_In.
- Mode 1: index of the lowest set bit of Data_In.
- Mode 2: first set bit found searching upward from pointer P, wrapping from N_INPUTS-1 to 0.
REQ-018 Round-robin pointer P (IDX_WIDTH bits) SHALL update only when a mode-2 result is loaded, to (granted index + 1).
- If the granted index is N_INPUTS-1, P wraps to 0.
- P is never N_INPUTS or above.
REQ-019 Mode-0 and mode-1 loads, and cycles with no load, SHALL leave P unchanged.
REQ-020 Mode_In changes SHALL take effect at the next load only; a held result is never altered.
REQ-021 Back-to-back operation SHALL be supported: a handshake and a new load in the same edge give one result per cycle with Valid_Out continuously 1.
REQ-022 Grant_Out SHALL always equal 1 << Encoded_Value_Out when Valid_Out=1, and SHALL be all-zero when Valid_Out=0.
REQ-023 X or Z SHALL never appear on any output after reset; no high-impedance output encoding is used.

Reset
REQ-024 While Reset_In=1, asynchronously and independent of the clock, the block SHALL force the following, including mid-hold with an unaccepted result, which is discarded:
- Valid_Out=0.
- Encoded_Value_Out=0.
- Grant_Out=0.
- P=0.
- State EMPTY.
REQ-025 The first load is possible on the first rising edge after Reset_In falls.

Verification
REQ-026 The bench SHALL cover these directed scenarios (N_INPUTS=16 unless stated):
- Mode 0, Data_In=0x8421, Enable_In=1, Ready_In=1 -> next cycle Valid_Out=1, Encoded_Value_Out=15, Grant_Out=0x8000.
- Mode 1, Data_In=0x8420 -> Encoded_Value_Out=5, Grant_Out=0x0020.
- Mode 2 from reset, Data_In=0x0009 held, Ready_In=1 for 4 cycles -> grant sequence 0, 3, 0, 3; P sequence 1, 4, 1, 4.
- Load 0x0100 in mode 0, Ready_In=0 for 3 cycles while Data_In changes to 0xFFFF -> Encoded_Value_Out stays 8; asserting Ready_In with Data_In=0 -> Valid_Out=0 next cycle.
- Enable_In=0 with Data_In=0xFFFF -> Valid_Out stays 0, Encoded_Value_Out=0; Reset_In asserted mid-FULL between edges -> Valid_Out=0 immediately.
- N_INPUTS=12, mode 2, Data_In=0x801 -> grants 0, 11, 0; P wraps 11->0.
